// File: rtl/phase_timer.sv
// Timing and request front-end for the traffic-light controller: 1 s tick prescaler,
// per-state seconds counter and a synchronised, debounced pedestrian request.
module phase_timer #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned COUNT_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ped_button,
  input  logic [1:0]         state_in,
  input  logic               ped_flag,
  output logic               tick,
  output logic [COUNT_W-1:0] count,
  output logic               pedestrian
);

  localparam int unsigned PreW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PreW-1:0]    PreMax   = PreW'(CLK_HZ - 1);
  localparam logic [DbW-1:0]     DbMax    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CountMax = '1;

  logic [PreW-1:0]    prescaler_q, prescaler_d;
  logic               tick_q, tick_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [1:0]         state_prev_q, state_prev_d;
  logic [1:0]         sync_q;
  logic [DbW-1:0]     db_cnt_q, db_cnt_d;
  logic               db_level_q, db_level_d;
  logic               db_prev_q;
  logic               pending_q, pending_d;
  logic               ped_rise;
  logic               ped_taken;

  assign tick       = tick_q;
  assign count      = count_q;
  assign pedestrian = pending_q & ~ped_flag;

  // The controller samples the request on the same edge that the registered tick is high.
  assign ped_taken = tick_q & pedestrian;
  assign ped_rise  = db_level_q & ~db_prev_q;

  always_comb begin
    prescaler_d = prescaler_q + 1'b1;
    tick_d      = 1'b0;
    if (prescaler_q == PreMax) begin
      prescaler_d = '0;
      tick_d      = 1'b1;
    end
  end

  always_comb begin
    count_d      = count_q;
    state_prev_d = state_prev_q;
    if (state_in != state_prev_q) begin
      count_d      = '0;
      state_prev_d = state_in;
    end else if (ped_taken) begin
      count_d = '0;
    end else if (tick_q && (count_q != CountMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Any return of the synchronised level to the accepted level restarts the stability window.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    if (sync_q[1] == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbMax) begin
      db_cnt_d   = '0;
      db_level_d = sync_q[1];
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // ped_flag discards everything; a fresh press beats the clearing tick.
  always_comb begin
    pending_d = pending_q;
    if (ped_flag) begin
      pending_d = 1'b0;
    end else if (ped_rise) begin
      pending_d = 1'b1;
    end else if (ped_taken) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q  <= '0;
      tick_q       <= 1'b0;
      count_q      <= '0;
      state_prev_q <= 2'b00;
      sync_q       <= 2'b00;
      db_cnt_q     <= '0;
      db_level_q   <= 1'b0;
      db_prev_q    <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      tick_q       <= tick_d;
      count_q      <= count_d;
      state_prev_q <= state_prev_d;
      sync_q       <= {sync_q[0], ped_button};
      db_cnt_q     <= db_cnt_d;
      db_level_q   <= db_level_d;
      db_prev_q    <= db_level_q;
      pending_q    <= pending_d;
    end
  end

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: a history-based reference model predicts every cycle's
// outputs, a monitor compares them, and directed scenarios check latencies and request counts.
module tb_phase_timer;

  localparam int ClkHz = 10;
  localparam int Db    = 4;
  localparam int CntW  = 4;
  localparam int CntMax = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic            ped_button;
  logic [1:0]      state_in;
  logic            ped_flag;
  logic            tick;
  logic [CntW-1:0] count;
  logic            pedestrian;

  int checks   = 0;
  int failures = 0;
  int rises    = 0;

  logic [5:0] exp_q[$];

  phase_timer #(
    .CLK_HZ         (ClkHz),
    .DEBOUNCE_CYCLES(Db),
    .COUNT_W        (CntW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ped_button(ped_button),
    .state_in  (state_in),
    .ped_flag  (ped_flag),
    .tick      (tick),
    .count     (count),
    .pedestrian(pedestrian)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: tick from elapsed edge count, seconds from the priority rules,
  // debounced level from the raw button history (stable for Db samples after 2-flop delay).
  int         n;
  bit         hist[$];
  logic [1:0] m_state_prev;
  int         m_count;
  bit         m_tick, m_pending, m_db, m_db_rose;

  function automatic bit btn_at(input int j);
    return (j >= 1) ? hist[j-1] : 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        n = 0;
        hist.delete();
        m_state_prev = 2'b00;
        m_count = 0;
        m_tick = 0;
        m_pending = 0;
        m_db = 0;
        m_db_rose = 0;
        exp_q.push_back(6'd0);
      end else begin
        bit tick_b, ped_b, db_b, rose_b, stable;
        tick_b = m_tick;
        ped_b  = m_pending & ~ped_flag;
        db_b   = m_db;
        rose_b = m_db_rose;
        n++;
        hist.push_back(ped_button);
        m_tick = ((n % ClkHz) == 0);
        if (state_in != m_state_prev) begin
          m_count = 0;
          m_state_prev = state_in;
        end else if (tick_b && ped_b) begin
          m_count = 0;
        end else if (tick_b) begin
          m_count = (m_count + 1 > CntMax) ? CntMax : m_count + 1;
        end
        stable = 1'b1;
        for (int k = 3; k <= Db + 1; k++) if (btn_at(n - k) != btn_at(n - 2)) stable = 1'b0;
        if (stable) m_db = btn_at(n - 2);
        m_db_rose = m_db && !db_b;
        if (ped_flag) m_pending = 0;
        else if (rose_b) m_pending = 1;
        else if (tick_b && ped_b) m_pending = 0;
        exp_q.push_back({m_tick, 4'(m_count), m_pending & ~ped_flag});
      end
    end
  end

  // Monitor: one expected output word per clock edge.
  initial begin
    logic [5:0] e;
    logic ped_prev;
    ped_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pedestrian && !ped_prev) rises++;
      ped_prev = pedestrian;
      if (exp_q.size() == 0) begin
        check("sb_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("sb_outputs", int'({tick, count, pedestrian}), int'(e));
      end
    end
  end

  task automatic edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ped_button = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic first_tick(input string name);
    int lat;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      edges(1);
      if (tick) begin
        lat = i;
        break;
      end
    end
    check(name, lat, ClkHz);
  endtask

  initial begin
    int r0, lat, guard, hold;
    reset = 1'b1;
    ped_button = 1'b0;
    state_in = 2'b00;
    ped_flag = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tick", int'(tick), 0);
    check("rst_count", int'(count), 0);
    check("rst_ped", int'(pedestrian), 0);
    @(negedge clk);
    reset = 1'b0;

    // Tick timing, counting and saturation.
    first_tick("first_tick");
    first_tick("tick_period");
    edges(70);
    check("count_9_ticks", int'(count), 8);
    edges(115);
    check("count_saturate", int'(count), CntMax);
    edges(50);
    check("count_stays_sat", int'(count), CntMax);

    // State change clears the count one clock later.
    do_reset();
    edges(75);
    check("count_before_change", int'(count), 7);
    @(negedge clk);
    state_in = 2'b10;
    edges(1);
    check("count_after_change", int'(count), 0);
    edges(5);
    check("count_next_tick", int'(count), 1);

    // Bouncing press then a stable hold.
    r0 = rises;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); ped_button = 1'b1;
      repeat (2) @(negedge clk);
      ped_button = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("no_req_bounce", rises - r0, 0);
    @(negedge clk);
    ped_button = 1'b1;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      edges(1);
      if (pedestrian) begin
        lat = i;
        break;
      end
    end
    check("ped_latency", lat, 2 + Db + 1);
    guard = 0;
    while (!tick && guard < 2 * ClkHz) begin
      edges(1);
      guard++;
    end
    check("ped_high_at_tick", int'(pedestrian), 1);
    edges(1);
    check("ped_drop_after_tick", int'(pedestrian), 0);
    check("count_cleared_by_ped", int'(count), 0);
    repeat (30) @(negedge clk);
    ped_button = 1'b0;
    repeat (30) @(negedge clk);
    check("one_request", rises - r0, 1);

    // Presses during a pedestrian sequence are discarded.
    r0 = rises;
    ped_flag = 1'b1;
    repeat (2) @(negedge clk);
    ped_button = 1'b1;
    repeat (15) @(negedge clk);
    ped_button = 1'b0;
    repeat (15) @(negedge clk);
    ped_flag = 1'b0;
    repeat (30) @(negedge clk);
    check("no_stale_request", rises - r0, 0);

    // Randomised traffic against the model.
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        ped_button = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 10);
      end
      hold--;
      if ($urandom_range(0, 59) == 0) state_in = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 39) == 0) ped_flag = ~ped_flag;
    end
    @(negedge clk);
    ped_flag = 1'b0;
    ped_button = 1'b0;

    // Reset mid-count with a request pending.
    do_reset();
    state_in = 2'b00;
    guard = 0;
    while (count != 4'd5 && guard < 100) begin
      edges(1);
      guard++;
    end
    check("reach_count5", int'(count), 5);
    @(negedge clk);
    ped_button = 1'b1;
    guard = 0;
    while (!pedestrian && guard < 20) begin
      edges(1);
      guard++;
    end
    check("pending_before_reset", int'(pedestrian), 1);
    @(negedge clk);
    reset = 1'b1;
    ped_button = 1'b0;
    #1;
    check("midrst_tick", int'(tick), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_ped", int'(pedestrian), 0);
    @(negedge clk);
    reset = 1'b0;
    first_tick("tick_after_reset");
    edges(40);
    check("no_req_after_reset", int'(pedestrian), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
